// File: rtl/vga_plot_arbiter.sv
// Round-robin owner of the VGA adapter write port for three pixel engines.
// The granted engine is cleared for one cycle, then run and muxed until done or timeout.
module vga_plot_arbiter #(
  parameter int XW             = 8,
  parameter int YW             = 7,
  parameter int CW             = 9,
  parameter int TIMEOUT_CYCLES = 16383
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      req,
  input  logic [2:0]      eng_done,
  input  logic [3*XW-1:0] eng_x,
  input  logic [3*YW-1:0] eng_y,
  input  logic [3*CW-1:0] eng_colour,
  output logic [2:0]      eng_resetn,
  output logic [2:0]      eng_enable,
  output logic [2:0]      grant,
  output logic [2:0]      done_pulse,
  output logic [XW-1:0]   vga_x,
  output logic [YW-1:0]   vga_y,
  output logic [CW-1:0]   vga_colour,
  output logic            vga_plot,
  output logic            busy,
  output logic            timeout_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, FINISH} state_t;

  state_t        state_reg;
  logic [2:0]    grant_reg;
  logic [1:0]    grant_idx_reg;
  logic [1:0]    last_grant_reg;
  logic [TW-1:0] count_reg;
  logic          timeout_err_reg;

  logic [XW-1:0] x_arr [3];
  logic [YW-1:0] y_arr [3];
  logic [CW-1:0] c_arr [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_unpack
    assign x_arr[gi] = eng_x[gi*XW +: XW];
    assign y_arr[gi] = eng_y[gi*YW +: YW];
    assign c_arr[gi] = eng_colour[gi*CW +: CW];
  end

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Priority order: last+1, last+2, last. Scan lowest first so the best hit overwrites.
  logic [1:0] prio [3];
  logic [1:0] winner_idx;
  always_comb begin
    prio[0]    = next_idx(last_grant_reg);
    prio[1]    = next_idx(prio[0]);
    prio[2]    = last_grant_reg;
    winner_idx = prio[2];
    for (int k = 2; k >= 0; k--) begin
      if (req[prio[k]]) winner_idx = prio[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      grant_reg       <= 3'b000;
      grant_idx_reg   <= 2'd0;
      last_grant_reg  <= 2'd2;
      count_reg       <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|req) begin
            grant_reg     <= 3'b001 << winner_idx;
            grant_idx_reg <= winner_idx;
            state_reg     <= CLEAR;
          end
        end
        CLEAR: begin
          count_reg <= '0;
          state_reg <= RUN;
        end
        RUN: begin
          count_reg <= count_reg + TW'(1);
          if (eng_done[grant_idx_reg]) begin
            state_reg <= FINISH;
          end else if (count_reg == TIMEOUT_LAST) begin
            timeout_err_reg <= 1'b1;
            state_reg       <= FINISH;
          end
        end
        FINISH: begin
          last_grant_reg <= grant_idx_reg;
          grant_reg      <= 3'b000;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic in_run;
  assign in_run = (state_reg == RUN);

  assign eng_resetn  = reset ? 3'b000 :
                       (state_reg == CLEAR) ? ~grant_reg : 3'b111;
  assign eng_enable  = in_run ? grant_reg : 3'b000;
  assign done_pulse  = (state_reg == FINISH) ? grant_reg : 3'b000;
  assign grant       = grant_reg;
  assign busy        = (state_reg != IDLE);
  assign timeout_err = timeout_err_reg;

  // The engine's done cycle carries no pixel, so plot is suppressed there.
  assign vga_x      = in_run ? x_arr[grant_idx_reg] : '0;
  assign vga_y      = in_run ? y_arr[grant_idx_reg] : '0;
  assign vga_colour = in_run ? c_arr[grant_idx_reg] : '0;
  assign vga_plot   = in_run & ~eng_done[grant_idx_reg];

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: behavioural pixel engines plus queue-based expectations.
module tb_vga_plot_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  req;
  logic [2:0]  eng_done;
  logic [23:0] eng_x;
  logic [20:0] eng_y;
  logic [26:0] eng_colour;
  logic [2:0]  eng_resetn, eng_enable, grant, done_pulse;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [8:0]  vga_colour;
  logic        vga_plot, busy, timeout_err;

  int tests_run = 0;
  int tests_failed = 0;

  vga_plot_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .eng_done(eng_done),
    .eng_x(eng_x), .eng_y(eng_y), .eng_colour(eng_colour),
    .eng_resetn(eng_resetn), .eng_enable(eng_enable), .grant(grant),
    .done_pulse(done_pulse), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy),
    .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Engine models: plot target[i] pixels while enabled, then hold done; target 0 never finishes.
  logic [15:0] cnt [3];
  logic [2:0]  done_r, stale, stale_arm;
  int          target [3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!eng_resetn[i]) begin
        cnt[i]    <= 16'd0;
        done_r[i] <= 1'b0;
        stale[i]  <= 1'b0;
      end else begin
        if (stale_arm[i]) stale[i] <= 1'b1;
        if (eng_enable[i] && !eng_done[i]) begin
          cnt[i] <= cnt[i] + 16'd1;
          if (int'(cnt[i]) + 1 == target[i]) done_r[i] <= 1'b1;
        end
      end
    end
  end

  assign eng_done   = done_r | stale;
  assign eng_x      = {8'hFF, 8'hFF, cnt[0][7:0]};
  assign eng_y      = {cnt[2][13:7], cnt[1][13:7], cnt[0][13:7]};
  assign eng_colour = {2'd2, cnt[2][6:0], 2'd1, cnt[1][6:0], 2'd0, cnt[0][6:0]};

  logic [23:0] exp_q [$];
  logic [2:0]  grant_q [$];
  logic [7:0]  xq [$];

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (eng_resetn !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_resetn actual=%b required=000", eng_resetn);
    end
    tests_run++;
    if ({grant, eng_enable, done_pulse, vga_x, vga_y, vga_colour, vga_plot, busy, timeout_err} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs grant=%b en=%b dp=%b x=%h plot=%b busy=%b terr=%b required all 0",
               grant, eng_enable, done_pulse, vga_x, vga_plot, busy, timeout_err);
    end
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (eng_resetn !== 3'b111 || busy !== 1'b0 || grant !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_release resetn=%b busy=%b grant=%b required 111/0/000", eng_resetn, busy, grant);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_single_job();
    int cyc, plots, first_plot, pulse_cyc;
    logic [15:0] kk;
    logic [23:0] e;
    target[0] = 6561;
    exp_q.delete();
    for (int k = 0; k < 6561; k++) begin
      kk = 16'(k);
      exp_q.push_back({kk[7:0], kk[13:7], 2'b00, kk[6:0]});
    end
    req = 3'b001;
    @(negedge clk);
    cyc = 1;
    tests_run++;
    if (eng_resetn !== 3'b110 || grant !== 3'b001 || eng_enable !== 3'b000 || vga_plot !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_clear resetn=%b grant=%b en=%b plot=%b required 110/001/000/0",
               eng_resetn, grant, eng_enable, vga_plot);
    end
    plots = 0; first_plot = -1; pulse_cyc = -1;
    while (pulse_cyc < 0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) req = 3'b000;
      if (vga_plot === 1'b1) begin
        plots++;
        if (first_plot < 0) first_plot = cyc;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL single_pixel extra plot at cycle %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          if ({vga_x, vga_y, vga_colour} !== e) begin
            tests_failed++;
            $display("FAIL single_pixel cycle=%0d actual=%h required=%h", cyc, {vga_x, vga_y, vga_colour}, e);
          end
        end
      end
      if (done_pulse !== 3'b000) begin
        pulse_cyc = cyc;
        tests_run++;
        if (done_pulse !== 3'b001) begin
          tests_failed++;
          $display("FAIL single_pulse_value actual=%b required=001", done_pulse);
        end
      end
    end
    tests_run++;
    if (first_plot != 2 || plots != 6561) begin
      tests_failed++;
      $display("FAIL single_plot_span first=%0d plots=%0d required first=2 plots=6561", first_plot, plots);
    end
    tests_run++;
    if (pulse_cyc != 6564) begin
      tests_failed++;
      $display("FAIL single_pulse_cycle actual=%0d required=6564", pulse_cyc);
    end
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_busy_after actual=%b required=0", busy);
    end
    $display("[TB] test_single_job plots=%0d pulse_cycle=%0d", plots, pulse_cyc);
  endtask

  task automatic test_round_robin();
    int cyc, prev_pulse, clears;
    logic [2:0] g;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    target[0] = 5; target[1] = 7; target[2] = 4;
    grant_q.delete();
    grant_q.push_back(3'b001); grant_q.push_back(3'b010);
    grant_q.push_back(3'b100); grant_q.push_back(3'b001);
    req = 3'b111;
    cyc = 0; prev_pulse = -1; clears = 0;
    while (clears < 4 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (eng_resetn !== 3'b111) begin
        clears++;
        g = grant_q.pop_front();
        tests_run++;
        if (grant !== g || eng_resetn !== ~g) begin
          tests_failed++;
          $display("FAIL rr_grant clear=%0d actual=%b resetn=%b required=%b", clears, grant, eng_resetn, g);
        end
        if (prev_pulse >= 0) begin
          tests_run++;
          if (cyc - prev_pulse != 2) begin
            tests_failed++;
            $display("FAIL rr_gap clear=%0d actual=%0d required=2 cycles after pulse", clears, cyc - prev_pulse);
          end
        end
      end
      if (done_pulse !== 3'b000) prev_pulse = cyc;
    end
    tests_run++;
    if (clears != 4) begin
      tests_failed++;
      $display("FAIL rr_clear_count actual=%0d required=4", clears);
    end
    req = 3'b000;
    cyc = 0;
    while (busy !== 1'b0 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rr_drain actual busy=%b required=0", busy);
    end
    $display("[TB] test_round_robin clears=%0d", clears);
  endtask

  task automatic test_stale_done();
    int cyc, plots, pulse_cyc;
    target[1] = 5;
    stale_arm = 3'b010;
    @(negedge clk);
    stale_arm = 3'b000;
    req = 3'b010;
    @(negedge clk);
    cyc = 1;
    tests_run++;
    if (grant !== 3'b010 || eng_resetn !== 3'b101 || vga_plot !== 1'b0) begin
      tests_failed++;
      $display("FAIL stale_clear grant=%b resetn=%b plot=%b required 010/101/0", grant, eng_resetn, vga_plot);
    end
    req = 3'b000;
    plots = 0; pulse_cyc = -1;
    while (pulse_cyc < 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (vga_plot === 1'b1) plots++;
      if (done_pulse !== 3'b000) begin
        pulse_cyc = cyc;
        tests_run++;
        if (done_pulse !== 3'b010) begin
          tests_failed++;
          $display("FAIL stale_pulse_value actual=%b required=010", done_pulse);
        end
      end
    end
    tests_run++;
    if (plots != 5 || pulse_cyc != 8) begin
      tests_failed++;
      $display("FAIL stale_run plots=%0d pulse_cycle=%0d required 5/8", plots, pulse_cyc);
    end
    @(negedge clk);
    $display("[TB] test_stale_done plots=%0d pulse_cycle=%0d", plots, pulse_cyc);
  endtask

  task automatic test_timeout();
    int cyc, plots, pulse_cyc;
    target[2] = 0;
    tests_run++;
    if (timeout_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_pre actual=%b required=0", timeout_err);
    end
    req = 3'b100;
    @(negedge clk);
    cyc = 1;
    req = 3'b000;
    plots = 0; pulse_cyc = -1;
    while (pulse_cyc < 0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (vga_plot === 1'b1) plots++;
      if (done_pulse !== 3'b000) begin
        pulse_cyc = cyc;
        tests_run++;
        if (done_pulse !== 3'b100 || timeout_err !== 1'b1) begin
          tests_failed++;
          $display("FAIL timeout_finish pulse=%b terr=%b required 100/1", done_pulse, timeout_err);
        end
      end
    end
    tests_run++;
    if (plots != 16383 || pulse_cyc != 16385) begin
      tests_failed++;
      $display("FAIL timeout_length plots=%0d pulse_cycle=%0d required 16383/16385", plots, pulse_cyc);
    end
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || timeout_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_after busy=%b terr=%b required 0/1", busy, timeout_err);
    end
    $display("[TB] test_timeout plots=%0d pulse_cycle=%0d", plots, pulse_cyc);
  endtask

  task automatic test_mux_isolation();
    logic [7:0] ex;
    target[0] = 20;
    xq.delete();
    for (int c = 0; c <= 24; c++) begin
      if (c >= 2 && c <= 22) xq.push_back(8'(c - 2));
      else xq.push_back(8'h00);
    end
    for (int c = 0; c <= 24; c++) begin
      if (c > 0) @(negedge clk);
      ex = xq.pop_front();
      tests_run++;
      if (vga_x !== ex) begin
        tests_failed++;
        $display("FAIL mux_x cycle=%0d actual=%h required=%h", c, vga_x, ex);
      end
      if (c == 0) req = 3'b001;
      if (c == 2) req = 3'b000;
      if (c == 23) begin
        tests_run++;
        if (done_pulse !== 3'b001) begin
          tests_failed++;
          $display("FAIL mux_pulse actual=%b required=001", done_pulse);
        end
      end
    end
    tests_run++;
    if (timeout_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_sticky actual=%b required=1", timeout_err);
    end
    $display("[TB] test_mux_isolation done");
  endtask

  task automatic test_reset_mid_run();
    int cyc, plots;
    target[0] = 6561;
    req = 3'b001;
    cyc = 0; plots = 0;
    while (plots < 100 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (vga_plot === 1'b1) plots++;
    end
    tests_run++;
    if (plots != 100) begin
      tests_failed++;
      $display("FAIL midrst_reach actual=%0d required=100 plots", plots);
    end
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({busy, grant, eng_enable, done_pulse, vga_plot, vga_x, timeout_err} !== '0 || eng_resetn !== 3'b000) begin
      tests_failed++;
      $display("FAIL midrst_outputs busy=%b grant=%b en=%b dp=%b plot=%b x=%h terr=%b resetn=%b required 0s/000",
               busy, grant, eng_enable, done_pulse, vga_plot, vga_x, timeout_err, eng_resetn);
    end
    @(negedge clk);
    tests_run++;
    if (done_pulse !== 3'b000 || eng_resetn !== 3'b000) begin
      tests_failed++;
      $display("FAIL midrst_hold dp=%b resetn=%b required 000/000", done_pulse, eng_resetn);
    end
    target[0] = 10;
    req = 3'b011;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (grant !== 3'b001) begin
      tests_failed++;
      $display("FAIL midrst_first_grant actual=%b required=001", grant);
    end
    req = 3'b000;
    cyc = 0;
    while (busy !== 1'b0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    $display("[TB] test_reset_mid_run plots_before_reset=%0d", plots);
  endtask

  initial begin
    reset = 1'b1;
    req = 3'b000;
    stale_arm = 3'b000;
    target[0] = 0; target[1] = 0; target[2] = 0;
    test_reset();
    test_single_job();
    test_round_robin();
    test_stale_done();
    test_timeout();
    test_mux_isolation();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
